// File: rtl/diff_apply.sv
// Multi-cycle "apply diff" helper: b = a ^ mask, where mask is one-hot at idx
// (or zero when idx >= WIDTH). The mask is built by a serial shift counter.
module diff_apply #(
   parameter int WIDTH = 32,
   parameter int IDXW  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [IDXW-1:0]  idx,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] mask,
   output logic             err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [IDXW-1:0] WIDTH_IDX = IDXW'(WIDTH);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_r;
   logic [IDXW-1:0]  idx_r;
   logic [IDXW-1:0]  cnt;
   logic [WIDTH-1:0] sreg;

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order inside the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         a_r   <= '0;
         idx_r <= '0;
         cnt   <= '0;
         sreg  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         b     <= '0;
         mask  <= '0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_r   <= a;
                  idx_r <= idx;
                  busy  <= 1'b1;
                  if (idx < WIDTH_IDX) begin
                     state <= S_SHIFT;
                     cnt   <= '0;
                     sreg  <= WIDTH'(1);
                     err   <= 1'b0;
                  end else begin
                     // idx == WIDTH means "operands equal": no bit to flip
                     state <= S_DONE;
                     done  <= 1'b1;
                     mask  <= '0;
                     b     <= a;
                     err   <= (idx > WIDTH_IDX);
                  end
               end
            end
            S_SHIFT: begin
               // Compare before shifting so sreg never walks off the top
               if (cnt == idx_r) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  mask  <= sreg;
                  b     <= a_r ^ sreg;
               end else begin
                  sreg <= sreg << 1;
                  cnt  <= cnt + IDXW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diff_apply.sv
// Self-checking bench for diff_apply: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_diff_apply;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [5:0]  idx;
   logic        busy;
   logic        done;
   logic [31:0] b;
   logic [31:0] mask;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] prev_b    = '0;
   logic [31:0] prev_mask = '0;

   diff_apply #(.WIDTH(32), .IDXW(6)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .idx   (idx),
      .busy  (busy),
      .done  (done),
      .b     (b),
      .mask  (mask),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int lowest_set(input logic [31:0] v);
      for (int i = 0; i < 32; i++)
         if (v[i]) return i;
      return 32;
   endfunction

   // Starts an op at the current negedge (cycle T) and returns at the negedge
   // of the done cycle; optionally pulses start with a new idx mid-operation.
   task automatic run_op(input logic [31:0] av, input logic [5:0] iv, input bit pulse_mid);
      int          k;
      int          lat_exp;
      logic [31:0] exp_mask;
      logic [31:0] exp_b;
      logic        exp_err;
      exp_mask = (iv < 32) ? (32'd1 << iv) : 32'd0;
      exp_b    = av ^ exp_mask;
      exp_err  = (iv > 32);
      lat_exp  = (iv < 32) ? int'(iv) + 2 : 1;
      a = av; idx = iv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; idx = 6'($urandom);
      k = 1;
      while (!done && k < 100) begin
         check("busy_mid", busy, 1'b1);
         check("mask_hold", mask, prev_mask);
         check("b_hold", b, prev_b);
         if (pulse_mid && k == 2) begin
            start = 1'b1; idx = 6'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check("done_seen", done, 1'b1);
      check("latency", k, lat_exp);
      check("busy_done", busy, 1'b1);
      check("mask", mask, exp_mask);
      check("b", b, exp_b);
      check("err", err, exp_err);
      if (iv < 32) begin
         check("popcount", $countones(mask), 1);
         check("lowest_bit", lowest_set(av ^ b), iv);
      end
      prev_b    = exp_b;
      prev_mask = exp_mask;
   endtask

   // Cycle after done: back in IDLE, result held.
   task automatic finish_op();
      @(negedge clk);
      check("done_pulse", done, 1'b0);
      check("busy_after", busy, 1'b0);
      check("mask_after", mask, prev_mask);
      check("b_after", b, prev_b);
   endtask

   initial begin
      bit seen_done;
      rst = 1'b1; start = 1'b0; a = '0; idx = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_b", b, 32'h0);
      check("rst_mask", mask, 32'h0);
      check("rst_err", err, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      run_op(32'h0000_0000, 6'd0, 1'b0);  finish_op();
      run_op(32'hFFFF_FFFF, 6'd31, 1'b0); finish_op();
      run_op(32'h1234_5678, 6'd32, 1'b0); finish_op();
      run_op(32'h1234_5678, 6'd40, 1'b0); finish_op();

      // Mid-shift start ignored; start held through the done cycle is only
      // accepted in the following cycle.
      run_op(32'hA5A5_A5A5, 6'd4, 1'b1);
      check("a5_mask", mask, 32'h0000_0010);
      check("a5_b", b, 32'hA5A5_A5B5);
      a = 32'hDEAD_BEEF; idx = 6'd3; start = 1'b1;
      finish_op();
      run_op(32'hDEAD_BEEF, 6'd3, 1'b0); finish_op();

      // Reset in the middle of an idx=20 operation.
      a = 32'h0F0F_0F0F; idx = 6'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_b", b, 32'h0);
      check("mid_rst_mask", mask, 32'h0);
      check("mid_rst_err", err, 1'b0);
      seen_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      check("no_done_after_rst", seen_done, 1'b0);
      prev_b = '0; prev_mask = '0;
      run_op(32'h0000_0100, 6'd1, 1'b0); finish_op();

      // Reset and start together: request dropped.
      rst = 1'b1; start = 1'b1; a = 32'h5555_5555; idx = 6'd0;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_start_busy", busy, 1'b0);
      @(negedge clk);
      check("rst_start_busy2", busy, 1'b0);
      check("rst_start_done", done, 1'b0);
      prev_b = '0; prev_mask = '0;

      for (int it = 0; it < 1000; it++) begin
         run_op($urandom, 6'($urandom_range(0, 31)), 1'b0);
         finish_op();
      end
      for (int it = 0; it < 20; it++) begin
         run_op($urandom, 6'($urandom_range(32, 63)), 1'b0);
         finish_op();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
